// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_FENCE  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble is inserted.
module fetch_unit_if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        stall,
   input  logic        load,
   input  logic [31:0] word,
   input  logic [31:0] pc,
   output logic        valid_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d
);

   // IF -> ID boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_d    <= 1'b0;
         instr_d    <= NOP_INSTR;
         pc_d       <= 32'd0;
         pc_plus4_d <= 32'd0;
      end else if (flush) begin
         valid_d <= 1'b0;
         instr_d <= NOP_INSTR;
      end else if (stall) begin
         valid_d <= valid_d;
      end else if (load) begin
         valid_d    <= 1'b1;
         instr_d    <= word;
         pc_d       <= pc;
         pc_plus4_d <= pc + 32'd4;
      end else begin
         valid_d <= 1'b0;
         instr_d <= NOP_INSTR;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, single-outstanding imem request FSM, and the IF/ID register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic        valid_d,
   output logic [31:0] instr_d,
   output opcode_t     opcode_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d
);

   fetch_state_t state;
   logic [31:0]  pc_f;
   logic [31:0]  hold_buf;
   logic         load;
   logic [31:0]  load_word;

   assign imem_req_valid = (state == S_REQ) && !pc_src_e;
   assign imem_req_addr  = pc_f;

   // A word reaches IF/ID either straight from the response or from the hold buffer once stall lifts.
   assign load = !pc_src_e && !stall_d &&
                 (((state == S_WAIT) && imem_rsp_valid) || (state == S_HOLD));
   assign load_word = (state == S_HOLD) ? hold_buf : imem_rsp_data;

   // Fetch FSM and PC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_REQ;
         pc_f     <= RESET_PC;
         hold_buf <= 32'd0;
      end else if (pc_src_e) begin
         pc_f <= align_word(pc_target_e);
         // A request still in flight must have its response swallowed before fetching the target.
         if (((state == S_WAIT) || (state == S_DROP)) && !imem_rsp_valid)
            state <= S_DROP;
         else
            state <= S_REQ;
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (stall_d) begin
                     hold_buf <= imem_rsp_data;
                     state    <= S_HOLD;
                  end else begin
                     pc_f  <= pc_f + 32'd4;
                     state <= S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_d) begin
                  pc_f  <= pc_f + 32'd4;
                  state <= S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rsp_valid)
                  state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   fetch_unit_if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_d),
      .stall      (stall_d),
      .load       (load),
      .word       (load_word),
      .pc         (pc_f),
      .valid_d    (valid_d),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pc_plus4_d (pc_plus4_d)
   );

   assign opcode_d = opcode_t'(instr_d[6:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch, stall, redirect, flush and reset scenarios.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        stall_d = 1'b0;
   logic        flush_d = 1'b0;
   logic        pc_src_e = 1'b0;
   logic [31:0] pc_target_e = 32'd0;
   logic        valid_d;
   logic [31:0] instr_d;
   opcode_t     opcode_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .pc_src_e       (pc_src_e),
      .pc_target_e    (pc_target_e),
      .valid_d        (valid_d),
      .instr_d        (instr_d),
      .opcode_d       (opcode_d),
      .pc_d           (pc_d),
      .pc_plus4_d     (pc_plus4_d)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ifid_t;

   logic [31:0] exp_addr[$];
   ifid_t       exp_ifid[$];
   ifid_t       e_mon;
   int          checks = 0;
   int          errors = 0;

   // Memory model: one request in flight, response after lat extra cycles
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'd0;
   int          delay = 0;
   int          lat = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0010_0093;
         32'h0000_0004: return 32'h0050_0093;
         32'h0000_0008: return 32'h0020_8133;
         32'h0000_0100: return 32'h00A0_0113;
         32'h0000_0200: return 32'h0000_0063;
         default:       return 32'h0000_0013;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   task automatic cyc(input logic rdy, input logic src, input logic [31:0] tgt,
                      input logic st, input logic fl);
      @(negedge clk);
      imem_req_ready = rdy;
      pc_src_e       = src;
      pc_target_e    = tgt;
      stall_d        = st;
      flush_d        = fl;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      if (pend) begin
         if (delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
         end else begin
            delay--;
         end
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         pend      = 1'b1;
         pend_addr = imem_req_addr;
         delay     = lat;
      end
   endtask

   // Request monitor: every accepted request address is checked against the queue
   always @(negedge clk) begin
      #2;
      if (reset && imem_req_valid && imem_req_ready) begin
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_addr_unexpected actual=%h required=none", imem_req_addr);
         end else begin
            check("req_addr", imem_req_addr, exp_addr.pop_front());
         end
      end
   end

   // IF/ID monitor: a fresh load shows valid_d after an edge with neither stall nor flush
   always @(posedge clk) begin
      #1;
      if (reset && valid_d && !stall_d && !flush_d) begin
         if (exp_ifid.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ifid_unexpected actual=%h required=none", instr_d);
         end else begin
            e_mon = exp_ifid.pop_front();
            check("ifid_instr", instr_d, e_mon.instr);
            check("ifid_pc", pc_d, e_mon.pc);
            check("ifid_pc4", pc_plus4_d, e_mon.pc + 32'd4);
            check("ifid_opcode", {25'd0, opcode_d}, {25'd0, e_mon.instr[6:0]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid_d", valid_d, 1'b0);
      check("rst_instr_d", instr_d, 32'h0000_0013);
      check("rst_pc_d", pc_d, 32'd0);
      check("rst_pc_plus4_d", pc_plus4_d, 32'd0);
      check("rst_req_addr", imem_req_addr, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 1: zero-wait sequential fetch
      exp_addr.push_back(32'h0);
      exp_addr.push_back(32'h4);
      exp_addr.push_back(32'h8);
      exp_ifid.push_back('{instr: 32'h0010_0093, pc: 32'h0});
      exp_ifid.push_back('{instr: 32'h0050_0093, pc: 32'h4});
      exp_ifid.push_back('{instr: 32'h0020_8133, pc: 32'h8});
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("t1_valid_hi", valid_d, 1'b1);
      cyc(1, 0, 0, 0, 0);
      check("t1_valid_lo", valid_d, 1'b0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // 2: stall across the response moves the word into the hold buffer
      cyc(0, 1, 32'h4, 0, 1);
      exp_addr.push_back(32'h4);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      check("t2_hold_no_req", imem_req_valid, 1'b0);
      check("t2_hold_instr", instr_d, 32'h0000_0013);
      exp_ifid.push_back('{instr: 32'h0050_0093, pc: 32'h4});
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check("t2_next_req_valid", imem_req_valid, 1'b1);
      check("t2_next_req_addr", imem_req_addr, 32'h8);

      // 3: redirect while waiting, late response must be dropped
      lat = 1;
      exp_addr.push_back(32'h8);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 32'h100, 0, 1);
      cyc(0, 0, 0, 0, 0);
      lat = 0;
      cyc(0, 0, 0, 0, 0);
      check("t3_drop_valid_d", valid_d, 1'b0);
      check("t3_req_valid", imem_req_valid, 1'b1);
      check("t3_req_addr", imem_req_addr, 32'h100);

      // 4: redirect coinciding with a response, misaligned target
      exp_addr.push_back(32'h100);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 32'h203, 0, 1);
      exp_addr.push_back(32'h200);
      exp_ifid.push_back('{instr: 32'h0000_0063, pc: 32'h200});
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // 5: flush wins over stall
      cyc(0, 0, 0, 1, 1);
      check("t5_pre_valid", valid_d, 1'b1);
      cyc(0, 0, 0, 1, 0);
      check("t5_valid_d", valid_d, 1'b0);
      check("t5_instr_d", instr_d, 32'h0000_0013);
      check("t5_pc_f", imem_req_addr, 32'h204);

      // 6: asynchronous reset while holding
      exp_addr.push_back(32'h204);
      cyc(1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("t6_hold_no_req", imem_req_valid, 1'b0);
      check("t6_pre_pc4", pc_plus4_d, 32'h204);
      #2;
      reset   = 1'b0;
      pend    = 1'b0;
      stall_d = 1'b0;
      #1;
      check("t6_valid_d", valid_d, 1'b0);
      check("t6_instr_d", instr_d, 32'h0000_0013);
      check("t6_pc_d", pc_d, 32'd0);
      check("t6_pc_plus4_d", pc_plus4_d, 32'd0);
      check("t6_req_addr", imem_req_addr, 32'd0);
      check("t6_req_valid", imem_req_valid, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      exp_addr.push_back(32'h0);
      exp_ifid.push_back('{instr: 32'h0010_0093, pc: 32'h0});
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      check("left_req", exp_addr.size(), 32'd0);
      check("left_ifid", exp_ifid.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
